adc_multichannel_apb: RTL

- Parametrised successor to the single-channel APB ADC interface.
- APB3 slave that sequences an external SAR ADC across up to NCH multiplexed channels, single-shot or continuous scan.
- Converted samples are tagged with their channel and buffered in a FIFO for the CPU.
- Interrupt on FIFO threshold; sits on the mriscv APB peripheral bus beside the other APB slaves.

---
 rtl/adc_multichannel_apb.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_multichannel_apb.sv
// adc_multichannel_apb: APB3 slave that sequences an external SAR ADC across
// NCH multiplexed channels and buffers channel-tagged samples in a FIFO.
// Optional macro ADC_TIMEOUT_EN adds a BUSY watchdog (STATUS.TO).
module adc_multichannel_apb #(
    parameter int unsigned DATA_WIDTH     = 10,
    parameter int unsigned NCH            = 4,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic                                   PSEL,
    input  logic                                   PENABLE,
    input  logic                                   PWRITE,
    input  logic [31:0]                            PADDR,
    input  logic [31:0]                            PWDATA,
    input  logic [3:0]                             PSTRB,
    output logic                                   PREADY,
    output logic [31:0]                            PRDATA,
    output logic                                   PSLVERR,
    input  logic [DATA_WIDTH-1:0]                  DATA,
    input  logic                                   BUSY,
    output logic                                   SOC,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] CHSEL,
    output logic                                   IRQ
);
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned EW = DATA_WIDTH + 4;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StSel, StSoc, StWaitHi, StWaitLo} state_e;

    state_e              state_q, state_d;
    logic                en_q, cont_q;
    logic [NCH-1:0]      mask_q;
    logic [5:0]          thr_q;
    logic                ovf_q, irq_q;
    logic [CW-1:0]       ptr_q, ptr_d, chsel_q, chsel_d;
    logic [EW-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [AW:0]         count_q;
    logic                to_q, halt_q, timeout;

    // APB decode; PADDR[4:2] selects one of five registers
    logic        access, bad, wr_ok, rd_ok;
    logic [2:0]  idx;
    assign access  = PSEL & PENABLE;
    assign idx     = PADDR[4:2];
    assign bad     = (idx > 3'd4) | (PWRITE & (idx == 3'd2)) | (~PWRITE & (idx == 3'd3));
    assign wr_ok   = access & PWRITE & ~bad;
    assign rd_ok   = access & ~PWRITE & ~bad;
    assign PREADY  = access;
    assign PSLVERR = access & bad;

    logic [31:0] bmask, ctrl_rd, ctrl_new, status, fifo_rd;
    logic        ctrl_we, sts_we, start_req, ovf_clr, to_clr;
    assign bmask     = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};
    assign ctrl_new  = (ctrl_rd & ~bmask) | (PWDATA & bmask);
    assign ctrl_we   = wr_ok & (idx == 3'd0);
    assign sts_we    = wr_ok & (idx == 3'd1) & PSTRB[0];
    assign ovf_clr   = sts_we & PWDATA[3];
    assign to_clr    = sts_we & PWDATA[4];
    assign start_req = wr_ok & (idx == 3'd3) & PSTRB[0] & PWDATA[0];

    // FIFO status and push/pop arbitration (a pop frees the slot for a same-cycle push)
    logic empty, full, pop, push_req, push, ovf_set;
    logic [EW-1:0] head;
    logic [3:0]    ch4;
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop     = rd_ok & (idx == 3'd2) & ~empty;
    assign push    = push_req & (~full | pop);
    assign ovf_set = push_req & full & ~pop;
    assign head    = mem[rptr_q];

    // Register read views
    always_comb begin
        ctrl_rd            = '0;
        ctrl_rd[0]         = en_q;
        ctrl_rd[1]         = cont_q;
        ctrl_rd[8 +: NCH]  = mask_q;
        status             = '0;
        status[0]          = (state_q != StIdle);
        status[1]          = empty;
        status[2]          = full;
        status[3]          = ovf_q;
        status[4]          = to_q;
        status[8 +: AW+1]  = count_q;
        fifo_rd            = '0;
        ch4                = '0;
        ch4[CW-1:0]        = chsel_q;
        if (!empty) begin
            fifo_rd[DATA_WIDTH-1:0] = head[DATA_WIDTH-1:0];
            fifo_rd[19:16]          = head[EW-1 -: 4];
            fifo_rd[31]             = 1'b1;
        end
    end

    // Read data mux, zero outside a legal read access
    always_comb begin
        PRDATA = '0;
        if (rd_ok) begin
            case (idx)
                3'd0:    PRDATA = ctrl_rd;
                3'd1:    PRDATA = status;
                3'd2:    PRDATA = fifo_rd;
                3'd4:    PRDATA = {26'd0, thr_q};
                default: PRDATA = '0;
            endcase
        end
    end

    // Channel search: next masked channel from the pointer, lowest overall, any above current
    logic          sel_found, higher;
    logic [CW-1:0] sel_ch, low_ch;
    always_comb begin
        sel_found = 1'b0;
        higher    = 1'b0;
        sel_ch    = '0;
        low_ch    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                low_ch = CW'(i);
                if (i >= int'(ptr_q)) begin
                    sel_found = 1'b1;
                    sel_ch    = CW'(i);
                end
                if (i > int'(chsel_q)) higher = 1'b1;
            end
        end
    end

    // Scan FSM next state; clearing EN aborts from any state without a push
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        chsel_d  = chsel_q;
        push_req = 1'b0;
        case (state_q)
            StIdle: begin
                if (en_q && (mask_q != '0) && (start_req || (cont_q && !halt_q))) begin
                    state_d = StSel;
                    ptr_d   = '0;
                end
            end
            StSel: begin
                if (mask_q == '0) begin
                    state_d = StIdle;
                end else if (sel_found) begin
                    chsel_d = sel_ch;
                    state_d = StSoc;
                end else if (cont_q) begin
                    chsel_d = low_ch;
                    state_d = StSoc;
                end else begin
                    state_d = StIdle;
                end
            end
            StSoc:    state_d = StWaitHi;
            StWaitHi: begin
                if (BUSY)         state_d = StWaitLo;
                else if (timeout) state_d = StIdle;
            end
            StWaitLo: begin
                if (!BUSY) begin
                    push_req = 1'b1;
                    if (higher) begin
                        ptr_d   = chsel_q + 1'b1;
                        state_d = StSel;
                    end else if (cont_q) begin
                        ptr_d   = '0;
                        state_d = StSel;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (timeout) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!en_q) begin
            state_d  = StIdle;
            push_req = 1'b0;
        end
    end

    assign SOC   = (state_q == StSoc) & en_q;
    assign CHSEL = (state_q == StSel) ? chsel_d : chsel_q;
    assign IRQ   = irq_q;

    // Control registers, FSM state and FIFO pointers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            en_q    <= 1'b0;
            cont_q  <= 1'b0;
            mask_q  <= '0;
            thr_q   <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
            ptr_q   <= '0;
            chsel_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            chsel_q <= chsel_d;
            if (ctrl_we) begin
                en_q   <= ctrl_new[0];
                cont_q <= ctrl_new[1];
                mask_q <= ctrl_new[8 +: NCH];
            end
            if (wr_ok && (idx == 3'd4) && PSTRB[0]) thr_q <= PWDATA[5:0];
            ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
            irq_q <= ((7'(count_q) >= {1'b0, thr_q}) && (thr_q != '0)) | ovf_q | to_q;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Sample storage; contents are invisible while empty so no reset is needed
    always_ff @(posedge CLK) begin
        if (push) mem[wptr_q] <= {ch4, DATA};
    end

`ifdef ADC_TIMEOUT_EN
    logic [31:0] tcnt_q;
    logic        to_fire, en_toggle;
    assign timeout   = ((state_q == StWaitHi) || (state_q == StWaitLo)) &&
                       ((tcnt_q + 32'd1) >= TIMEOUT_CYCLES);
    assign to_fire   = en_q & timeout & (((state_q == StWaitHi) & ~BUSY) |
                                         ((state_q == StWaitLo) & BUSY));
    assign en_toggle = ctrl_we & (ctrl_new[0] != en_q);

    // Watchdog counter restarts on every state entry; a timeout halts continuous scanning
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tcnt_q <= '0;
            to_q   <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            if (state_d != state_q) tcnt_q <= '0;
            else if ((state_q == StWaitHi) || (state_q == StWaitLo)) tcnt_q <= tcnt_q + 32'd1;
            to_q <= to_fire | (to_q & ~to_clr);
            if (to_fire)                     halt_q <= 1'b1;
            else if (start_req || en_toggle) halt_q <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
    assign to_q    = 1'b0;
    assign halt_q  = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{PADDR[31:5], PADDR[1:0], ctrl_new, to_clr};

endmodule
